// File: rtl/mips_run_controller.sv
// mips_run_controller
// Holds the MIPS core in reset for RESET_CYCLES edges after system reset,
// then watches the commit stream and stops the core on halt, illegal PC,
// self-loop or cycle timeout, reporting a sticky done flag and status code.
module mips_run_controller #(
    parameter int                    PC_WIDTH       = 32,
    parameter int                    CNT_WIDTH      = 32,
    parameter int                    RESET_CYCLES   = 50,
    parameter int                    MAX_CYCLES     = 100000,
    parameter logic [31:0]           HALT_INSTR     = 32'h1000ffff,
    parameter logic [PC_WIDTH-1:0]   PC_BASE        = PC_WIDTH'(32'h00003000),
    parameter logic [PC_WIDTH-1:0]   PC_LIMIT       = PC_WIDTH'(32'h00004000),
    parameter int                    LOOP_THRESHOLD = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 core_reset,
    input  logic                 commit_valid,
    input  logic [PC_WIDTH-1:0]  commit_pc,
    input  logic [31:0]          commit_instr,
    output logic                 running,
    output logic                 done,
    output logic [2:0]           status,
    output logic [CNT_WIDTH-1:0] cycle_count,
    output logic [CNT_WIDTH-1:0] instr_count,
    output logic [PC_WIDTH-1:0]  last_pc
);

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] STS_NONE    = 3'd0;
    localparam logic [2:0] STS_HALT    = 3'd1;
    localparam logic [2:0] STS_RANGE   = 3'd2;
    localparam logic [2:0] STS_LOOP    = 3'd3;
    localparam logic [2:0] STS_TIMEOUT = 3'd4;

    localparam logic [31:0]          HOLD_LAST = 32'(RESET_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CYC_MAX   = CNT_WIDTH'(MAX_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LOOP_THR  = CNT_WIDTH'(LOOP_THRESHOLD);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    // Counters stop at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : (v + CNT_ONE);
    endfunction

    logic [1:0]           r_state;
    logic [31:0]          r_hold_cnt;
    logic [CNT_WIDTH-1:0] r_cycle_cnt;
    logic [CNT_WIDTH-1:0] r_instr_cnt;
    logic [CNT_WIDTH-1:0] r_loop_cnt;
    logic [PC_WIDTH-1:0]  r_last_pc;
    logic [2:0]           r_status;

    logic [CNT_WIDTH-1:0] w_cycle_next;
    logic [CNT_WIDTH-1:0] w_instr_next;
    logic [CNT_WIDTH-1:0] w_loop_next;
    logic                 w_is_halt;
    logic                 w_out_range;
    logic                 w_self_loop;
    logic                 w_timeout;
    logic                 w_term;
    logic [2:0]           w_term_code;

    assign w_cycle_next = sat_inc(r_cycle_cnt);
    assign w_instr_next = sat_inc(r_instr_cnt);

    // A zero loop counter means no commit has been accepted yet, so the
    // reset value of last_pc must not be mistaken for a repeated PC.
    assign w_loop_next  = ((r_loop_cnt != '0) && (commit_pc == r_last_pc))
                          ? sat_inc(r_loop_cnt) : CNT_ONE;

    assign w_is_halt    = commit_valid && (commit_instr == HALT_INSTR);
    assign w_out_range  = commit_valid && ((commit_pc < PC_BASE) || (commit_pc >= PC_LIMIT));
    assign w_self_loop  = commit_valid && (w_loop_next == LOOP_THR);
    assign w_timeout    = (w_cycle_next == CYC_MAX);

    // Termination priority: halt, then PC range, then self-loop, then timeout.
    always_comb begin
        w_term      = 1'b1;
        w_term_code = STS_NONE;
        if (w_is_halt) begin
            w_term_code = STS_HALT;
        end else if (w_out_range) begin
            w_term_code = STS_RANGE;
        end else if (w_self_loop) begin
            w_term_code = STS_LOOP;
        end else if (w_timeout) begin
            w_term_code = STS_TIMEOUT;
        end else begin
            w_term      = 1'b0;
        end
    end

    // Run-control state machine with hold timer, counters and commit tracking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_cycle_cnt <= '0;
            r_instr_cnt <= '0;
            r_loop_cnt  <= '0;
            r_last_pc   <= '0;
            r_status    <= STS_NONE;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    if (r_hold_cnt == HOLD_LAST) begin
                        r_state <= ST_RUN;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 32'd1;
                    end
                end
                ST_RUN: begin
                    r_cycle_cnt <= w_cycle_next;
                    if (commit_valid) begin
                        r_instr_cnt <= w_instr_next;
                        r_last_pc   <= commit_pc;
                        r_loop_cnt  <= w_loop_next;
                    end
                    if (w_term) begin
                        r_state  <= ST_DONE;
                        r_status <= w_term_code;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_DONE;
                end
                default: begin
                    r_state <= ST_HOLD;
                end
            endcase
        end
    end

    assign core_reset  = (r_state != ST_RUN);
    assign running     = (r_state == ST_RUN);
    assign done        = (r_state == ST_DONE);
    assign status      = r_status;
    assign cycle_count = r_cycle_cnt;
    assign instr_count = r_instr_cnt;
    assign last_pc     = r_last_pc;

endmodule

// File: tb/tb_mips_run_controller.sv
// tb_mips_run_controller
// Table-driven commit sequences with a scoreboard queue, plus hand-written
// timeout and mid-run reset sequences.
module tb_mips_run_controller;

    localparam logic [31:0] HALT = 32'h1000ffff;
    localparam logic [31:0] NOP  = 32'h08000c04;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        core_reset;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc = 32'h0;
    logic [31:0] commit_instr = 32'h0;
    logic        running;
    logic        done;
    logic [2:0]  status;
    logic [31:0] cycle_count;
    logic [31:0] instr_count;
    logic [31:0] last_pc;

    mips_run_controller #(
        .PC_WIDTH       (32),
        .CNT_WIDTH      (32),
        .RESET_CYCLES   (50),
        .MAX_CYCLES     (20),
        .HALT_INSTR     (HALT),
        .PC_BASE        (32'h00003000),
        .PC_LIMIT       (32'h00004000),
        .LOOP_THRESHOLD (4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .core_reset   (core_reset),
        .commit_valid (commit_valid),
        .commit_pc    (commit_pc),
        .commit_instr (commit_instr),
        .running      (running),
        .done         (done),
        .status       (status),
        .cycle_count  (cycle_count),
        .instr_count  (instr_count),
        .last_pc      (last_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          scen;
        logic        v;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        done;
        logic [2:0]  st;
        logic [31:0] ic;
        logic [31:0] lp;
        logic [31:0] cc;
    } vec_t;

    typedef struct {
        int          scen;
        int          step;
        logic        done;
        logic [2:0]  st;
        logic [31:0] ic;
        logic [31:0] lp;
        logic [31:0] cc;
    } exp_t;

    vec_t tbl[$];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=0x%0h want=0x%0h", nm, got, want);
        end
    endtask

    task automatic add(input int scen, input logic v, input logic [31:0] pc, input logic [31:0] instr,
                       input logic d, input logic [2:0] st, input logic [31:0] ic,
                       input logic [31:0] lp, input logic [31:0] cc);
        vec_t r;
        r.scen = scen; r.v = v; r.pc = pc; r.instr = instr;
        r.done = d; r.st = st; r.ic = ic; r.lp = lp; r.cc = cc;
        tbl.push_back(r);
    endtask

    // Drive one commit cycle (called at a negedge) and queue its expected result.
    task automatic apply(input int scen, input int step, input logic v, input logic [31:0] pc,
                         input logic [31:0] instr, input logic d, input logic [2:0] st,
                         input logic [31:0] ic, input logic [31:0] lp, input logic [31:0] cc);
        exp_t e;
        commit_valid = v;
        commit_pc    = pc;
        commit_instr = instr;
        e.scen = scen; e.step = step; e.done = d; e.st = st; e.ic = ic; e.lp = lp; e.cc = cc;
        sbq.push_back(e);
        @(negedge clk);
    endtask

    // Scoreboard: compare outputs shortly after each rising edge.
    always @(posedge clk) begin : scoreboard
        exp_t  e;
        string tag;
        #2;
        if (sbq.size() > 0) begin
            e   = sbq.pop_front();
            tag = $sformatf("s%0d.%0d", e.scen, e.step);
            chk({tag, ".done"},       32'(done),       32'(e.done));
            chk({tag, ".status"},     32'(status),     32'(e.st));
            chk({tag, ".instr_count"}, instr_count,    e.ic);
            chk({tag, ".last_pc"},    last_pc,         e.lp);
            chk({tag, ".cycle_count"}, cycle_count,    e.cc);
            chk({tag, ".running"},    32'(running),    32'(!e.done));
            chk({tag, ".core_reset"}, 32'(core_reset), 32'(e.done));
        end
    end

    // Assert reset (at a negedge), check outputs before any edge, release and
    // count the rising edges that see core_reset high.
    task automatic do_reset(input logic noise);
        int n;
        reset        = 1'b1;
        commit_valid = 1'b0;
        #1;
        chk("rst.core_reset",  32'(core_reset), 32'd1);
        chk("rst.running",     32'(running),    32'd0);
        chk("rst.done",        32'(done),       32'd0);
        chk("rst.status",      32'(status),     32'd0);
        chk("rst.cycle_count", cycle_count,     32'd0);
        chk("rst.instr_count", instr_count,     32'd0);
        chk("rst.last_pc",     last_pc,         32'd0);
        if (noise) begin
            commit_valid = 1'b1;
            commit_pc    = 32'h00002000;
            commit_instr = HALT;
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        while (core_reset === 1'b1 && n < 100) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        commit_valid = 1'b0;
        commit_pc    = 32'h0;
        commit_instr = 32'h0;
        chk("hold.edges",       32'(n),       32'd50);
        chk("hold.running",     32'(running), 32'd1);
        chk("hold.done",        32'(done),    32'd0);
        chk("hold.instr_count", instr_count,  32'd0);
        chk("hold.cycle_count", cycle_count,  32'd0);
        chk("hold.last_pc",     last_pc,      32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int step;
        // scen, v, pc, instr, done, status, instr_count, last_pc, cycle_count
        add(1, 1'b1, 32'h3000, NOP,  1'b0, 3'd0, 32'd1, 32'h3000, 32'd1);
        add(1, 1'b1, 32'h3004, NOP,  1'b0, 3'd0, 32'd2, 32'h3004, 32'd2);
        add(1, 1'b1, 32'h3008, NOP,  1'b0, 3'd0, 32'd3, 32'h3008, 32'd3);
        add(1, 1'b1, 32'h300c, HALT, 1'b1, 3'd1, 32'd4, 32'h300c, 32'd4);
        add(1, 1'b1, 32'h3010, NOP,  1'b1, 3'd1, 32'd4, 32'h300c, 32'd4);
        add(2, 1'b1, 32'h2ffc, NOP,  1'b1, 3'd2, 32'd1, 32'h2ffc, 32'd1);
        add(3, 1'b1, 32'h3ffc, NOP,  1'b0, 3'd0, 32'd1, 32'h3ffc, 32'd1);
        add(3, 1'b1, 32'h4000, NOP,  1'b1, 3'd2, 32'd2, 32'h4000, 32'd2);
        add(4, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd1, 32'h3010, 32'd1);
        add(4, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd2, 32'h3010, 32'd2);
        add(4, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd3, 32'h3010, 32'd3);
        add(4, 1'b1, 32'h3010, NOP,  1'b1, 3'd3, 32'd4, 32'h3010, 32'd4);
        add(5, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd1, 32'h3010, 32'd1);
        add(5, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd2, 32'h3010, 32'd2);
        add(5, 1'b1, 32'h3010, NOP,  1'b0, 3'd0, 32'd3, 32'h3010, 32'd3);
        add(5, 1'b1, 32'h3014, NOP,  1'b0, 3'd0, 32'd4, 32'h3014, 32'd4);
        add(5, 1'b0, 32'h2000, HALT, 1'b0, 3'd0, 32'd4, 32'h3014, 32'd5);
        add(5, 1'b1, 32'h3014, NOP,  1'b0, 3'd0, 32'd5, 32'h3014, 32'd6);
        add(5, 1'b1, 32'h3014, NOP,  1'b0, 3'd0, 32'd6, 32'h3014, 32'd7);
        add(5, 1'b1, 32'h3014, NOP,  1'b1, 3'd3, 32'd7, 32'h3014, 32'd8);
        add(6, 1'b1, 32'h5000, HALT, 1'b1, 3'd1, 32'd1, 32'h5000, 32'd1);

        @(negedge clk);

        for (int s = 1; s <= 6; s++) begin
            do_reset(1'b0);
            step = 0;
            for (int i = 0; i < tbl.size(); i++) begin
                if (tbl[i].scen == s) begin
                    step++;
                    apply(s, step, tbl[i].v, tbl[i].pc, tbl[i].instr, tbl[i].done,
                          tbl[i].st, tbl[i].ic, tbl[i].lp, tbl[i].cc);
                end
            end
        end

        // Timeout with no commits; commits offered after DONE must be ignored.
        do_reset(1'b0);
        for (int j = 1; j <= 22; j++) begin
            apply(7, j, (j > 20), 32'h00002000, HALT, (j >= 20),
                  (j >= 20) ? 3'd4 : 3'd0, 32'd0, 32'd0,
                  (j >= 20) ? 32'd20 : 32'(j));
        end

        // Reset mid-run at cycle_count=7, then the hold repeats with commits
        // offered during HOLD that must be ignored.
        do_reset(1'b0);
        for (int j = 1; j <= 7; j++) begin
            apply(8, j, 1'b1, 32'h3000 + 32'(4 * (j - 1)), NOP, 1'b0, 3'd0,
                  32'(j), 32'h3000 + 32'(4 * (j - 1)), 32'(j));
        end
        do_reset(1'b1);
        apply(8, 8, 1'b1, 32'h3100, HALT, 1'b1, 3'd1, 32'd1, 32'h3100, 32'd1);

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
